// File: rtl/fetch_pipe_skid.sv
// Fetch->decode pipeline register with a 2-entry skid buffer; flush/reset insert NOP bubbles.
// Latency: 1 cycle from accept to out_valid when empty; pass-through per cycle when streaming.
// Backpressure: in_ready is registered and drops only when both main and skid entries hold beats.
module fetch_pipe_skid #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      pre_address_in,
    input  logic [31:0]      instruction_in,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      pre_address_out,
    output logic [31:0]      instruction_out,
    output logic [CNT_W-1:0] bubble_count
);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } beat_t;

    state_t state;
    beat_t  main_q;
    beat_t  skid_q;
    beat_t  in_beat;
    logic   accept;
    logic   pop;

    assign in_beat   = '{pc: pre_address_in, instr: instruction_in};
    assign out_valid = (state != EMPTY);
    assign in_ready  = (state != FULL);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign pre_address_out = main_q.pc;
    assign instruction_out = main_q.instr;

    // main_q.instr is forced to NOP whenever the buffer drains, so the output
    // needs no mux; the pc deliberately keeps its last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= EMPTY;
            main_q       <= '{pc: 32'h0, instr: NOP_INSTR};
            skid_q       <= '0;
            bubble_count <= '0;
        end else begin
            if (!out_valid && (bubble_count != {CNT_W{1'b1}}))
                bubble_count <= bubble_count + CNT_W'(1);

            if (flush) begin
                state        <= EMPTY;
                main_q.instr <= NOP_INSTR;
                skid_q       <= '0;
            end else begin
                case (state)
                    EMPTY: begin
                        if (accept) begin
                            main_q <= in_beat;
                            state  <= ONE;
                        end
                    end
                    ONE: begin
                        if (accept && pop) begin
                            main_q <= in_beat;
                        end else if (accept) begin
                            skid_q <= in_beat;
                            state  <= FULL;
                        end else if (pop) begin
                            main_q.instr <= NOP_INSTR;
                            state        <= EMPTY;
                        end
                    end
                    FULL: begin
                        if (pop) begin
                            main_q <= skid_q;
                            state  <= ONE;
                        end
                    end
                    default: state <= EMPTY;
                endcase
            end
        end
    end

endmodule
